// File: rtl/select_next_hop_if.sv
`default_nettype none
// ============================================================================
// Module      : select_next_hop_if
// Description : Control and memory bus bundle for the next-hop selection
//               stage. Signal prefixes are from the selection block's point
//               of view: i_* flow into it, o_* flow out of it.
//   i_en       arm the block and clear the previous result
//   i_start    launch a neighbour scan
//   i_data_in  memory read data (valid the cycle after o_address)
//   o_address  memory byte address (registered)
//   o_wr_en    memory write strobe (registered)
//   o_data_out memory write data (registered)
//   o_next_hop selected neighbour ID, all ones if none
//   o_found    an eligible neighbour was selected
//   o_done     scan complete, held until the next i_en
// Revision    : 1.0 - initial release
// ============================================================================
interface select_next_hop_if #(
   parameter int WORD_WIDTH = 16
);
   logic                  i_en;
   logic                  i_start;
   logic [WORD_WIDTH-1:0] i_data_in;
   logic [10:0]           o_address;
   logic                  o_wr_en;
   logic [WORD_WIDTH-1:0] o_data_out;
   logic [WORD_WIDTH-1:0] o_next_hop;
   logic                  o_found;
   logic                  o_done;

   modport slave (
      input  i_en, i_start, i_data_in,
      output o_address, o_wr_en, o_data_out, o_next_hop, o_found, o_done
   );

   modport master (
      output i_en, i_start, i_data_in,
      input  o_address, o_wr_en, o_data_out, o_next_hop, o_found, o_done
   );
endinterface
`default_nettype wire

// File: rtl/select_next_hop.sv
`default_nettype none
// ============================================================================
// Module      : select_next_hop
// Description : Scans the neighbour table in shared node memory and selects
//               the eligible neighbour (non-zero sink count) with the lowest
//               Q-value; the lowest index wins ties. The chosen ID is written
//               back to the nextHop word and presented on o_next_hop.
//   clk  system clock, posedge
//   rst  synchronous active-high reset
//   bus  select_next_hop_if.slave (control, memory and result signals)
// Revision    : 1.0 - initial release
// ============================================================================
module select_next_hop #(
   parameter int WORD_WIDTH    = 16,
   parameter int MAX_NEIGHBORS = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   select_next_hop_if.slave      bus
);

   localparam logic [10:0] C_ADDR_NCNT = 11'h68A;
   localparam logic [10:0] C_ADDR_NHOP = 11'h68C;
   localparam logic [10:0] C_ADDR_SINK = 11'h68E;
   localparam logic [10:0] C_ADDR_QVAL = 11'h1C8;
   localparam logic [10:0] C_ADDR_NID  = 11'h6AE;
   localparam logic [WORD_WIDTH-1:0] C_NO_HOP = '1;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_WAIT  = 4'd1,
      S_NCNT  = 4'd2,
      S_SCNT  = 4'd3,
      S_QVAL  = 4'd4,
      S_NID   = 4'd5,
      S_NEXT  = 4'd6,
      S_WRITE = 4'd7,
      S_WDONE = 4'd8
   } state_t;

   state_t                r_state, w_state;
   logic [4:0]            r_i, w_i;
   logic [4:0]            r_count, w_count;
   logic [WORD_WIDTH-1:0] r_best_q, w_best_q;
   logic [10:0]           r_address, w_address;
   logic                  r_wr_en, w_wr_en;
   logic [WORD_WIDTH-1:0] r_data_out, w_data_out;
   logic [WORD_WIDTH-1:0] r_next_hop, w_next_hop;
   logic                  r_found, w_found;
   logic                  r_done, w_done;

   logic [4:0]            w_count_clamped;
   logic [4:0]            w_i_inc;

   // Word-array element address: base + 2*idx.
   function automatic logic [10:0] f_slot(input logic [10:0] base, input logic [4:0] idx);
      return base + {5'd0, idx, 1'b0};
   endfunction

   assign w_count_clamped = (bus.i_data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ?
                            5'(MAX_NEIGHBORS) : bus.i_data_in[4:0];
   assign w_i_inc = r_i + 5'd1;

   always_comb begin
      w_state    = r_state;
      w_i        = r_i;
      w_count    = r_count;
      w_best_q   = r_best_q;
      w_address  = r_address;
      w_wr_en    = r_wr_en;
      w_data_out = r_data_out;
      w_next_hop = r_next_hop;
      w_found    = r_found;
      w_done     = r_done;

      case (r_state)
         S_IDLE: begin
            if (bus.i_en) begin
               w_done     = 1'b0;
               w_found    = 1'b0;
               w_i        = 5'd0;
               w_next_hop = C_NO_HOP;
               w_address  = C_ADDR_NCNT;
               w_state    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.i_start) begin
               w_address = C_ADDR_NCNT;
               w_state   = S_NCNT;
            end
         end
         S_NCNT: begin
            w_count = w_count_clamped;
            if (w_count_clamped == 5'd0) begin
               w_state = S_WRITE;
            end else begin
               w_address = f_slot(C_ADDR_SINK, 5'd0);
               w_state   = S_SCNT;
            end
         end
         S_SCNT: begin
            // A neighbour with no sinks behind it cannot be a next hop.
            if (bus.i_data_in == '0) begin
               w_state = S_NEXT;
            end else begin
               w_address = f_slot(C_ADDR_QVAL, r_i);
               w_state   = S_QVAL;
            end
         end
         S_QVAL: begin
            // Strict less-than keeps the earlier index on equal Q-values.
            if (!r_found || (bus.i_data_in < r_best_q)) begin
               w_best_q  = bus.i_data_in;
               w_found   = 1'b1;
               w_address = f_slot(C_ADDR_NID, r_i);
               w_state   = S_NID;
            end else begin
               w_state = S_NEXT;
            end
         end
         S_NID: begin
            w_next_hop = bus.i_data_in;
            w_state    = S_NEXT;
         end
         S_NEXT: begin
            w_i = w_i_inc;
            if (w_i_inc == r_count) begin
               w_state = S_WRITE;
            end else begin
               w_address = f_slot(C_ADDR_SINK, w_i_inc);
               w_state   = S_SCNT;
            end
         end
         S_WRITE: begin
            w_address  = C_ADDR_NHOP;
            w_data_out = r_found ? r_next_hop : C_NO_HOP;
            w_wr_en    = 1'b1;
            w_state    = S_WDONE;
         end
         S_WDONE: begin
            w_wr_en = 1'b0;
            w_done  = 1'b1;
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_i        <= 5'd0;
         r_count    <= 5'd0;
         r_best_q   <= '0;
         r_address  <= C_ADDR_NCNT;
         r_wr_en    <= 1'b0;
         r_data_out <= '0;
         r_next_hop <= C_NO_HOP;
         r_found    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_i        <= w_i;
         r_count    <= w_count;
         r_best_q   <= w_best_q;
         r_address  <= w_address;
         r_wr_en    <= w_wr_en;
         r_data_out <= w_data_out;
         r_next_hop <= w_next_hop;
         r_found    <= w_found;
         r_done     <= w_done;
      end
   end

   assign bus.o_address  = r_address;
   assign bus.o_wr_en    = r_wr_en;
   assign bus.o_data_out = r_data_out;
   assign bus.o_next_hop = r_next_hop;
   assign bus.o_found    = r_found;
   assign bus.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_select_next_hop.sv
`default_nettype none
// ============================================================================
// Module      : tb_select_next_hop
// Description : Scoreboard bench for select_next_hop. Stimulus loads a word
//               memory model, pushes the expected write and result, and runs
//               a scan; a negedge monitor pops and compares on each write
//               strobe and each rising done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_select_next_hop;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   select_next_hop_if #(.WORD_WIDTH(16)) bus_if ();

   select_next_hop #(
      .WORD_WIDTH    (16),
      .MAX_NEIGHBORS (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   logic [15:0] mem [0:2047];
   assign bus_if.i_data_in = mem[bus_if.o_address];

   typedef struct packed {
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic [15:0] nh;
      logic        found;
      logic [31:0] lat;
   } res_t;

   wr_t  wq[$];
   res_t rq[$];
   wr_t  mon_w;
   res_t mon_r;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int start_cyc = 0;
   int wr_base = 0;
   int wr_total = 0;
   int q0_cnt = 0;
   int qhi_cnt = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: address watch, write scoreboard, result scoreboard.
   always @(negedge clk) begin
      if (bus_if.o_address == 11'h1C8) q0_cnt++;
      if (bus_if.o_address >= 11'h1E8 && bus_if.o_address <= 11'h206) qhi_cnt++;
      if (bus_if.o_wr_en === 1'b1) begin
         wr_total++;
         if (wq.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            mon_w = wq.pop_front();
            chk("wr_addr", {21'd0, bus_if.o_address}, {21'd0, mon_w.addr});
            chk("wr_data", {16'd0, bus_if.o_data_out}, {16'd0, mon_w.data});
         end
      end
      if (bus_if.o_done === 1'b1 && prev_done !== 1'b1) begin
         if (rq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_r = rq.pop_front();
            chk("next_hop", {16'd0, bus_if.o_next_hop}, {16'd0, mon_r.nh});
            chk("found", {31'd0, bus_if.o_found}, {31'd0, mon_r.found});
            chk("latency", cyc - start_cyc, mon_r.lat);
            chk("writes_per_scan", wr_total - wr_base, 32'd1);
         end
      end
      prev_done = bus_if.o_done;
   end

   task automatic clear_mem();
      for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
   endtask

   task automatic set_nb(input int i, input logic [15:0] s, input logic [15:0] q, input logic [15:0] id);
      mem[11'h68E + 2*i] = s;
      mem[11'h1C8 + 2*i] = q;
      mem[11'h6AE + 2*i] = id;
   endtask

   task automatic arm_and_start();
      @(negedge clk);
      bus_if.i_en = 1'b1;
      @(negedge clk);
      bus_if.i_en    = 1'b0;
      bus_if.i_start = 1'b1;
      @(negedge clk);
      bus_if.i_start = 1'b0;
      start_cyc      = cyc;
   endtask

   task automatic run_scan(input logic [15:0] cnt, input logic [15:0] nh, input logic fnd, input int lat);
      res_t r;
      wr_t  w;
      int   t;
      mem[11'h68A] = cnt;
      r.nh = nh; r.found = fnd; r.lat = lat;
      w.addr = 11'h68C; w.data = nh;
      rq.push_back(r);
      wq.push_back(w);
      wr_base = wr_total;
      arm_and_start();
      t = 0;
      while (bus_if.o_done !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      if (t >= 300) begin
         chk("done_timeout", 32'd0, 32'd1);
         rq.delete();
         wq.delete();
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_address",  {21'd0, bus_if.o_address},  32'h68A);
      chk("rst_wr_en",    {31'd0, bus_if.o_wr_en},    32'd0);
      chk("rst_data_out", {16'd0, bus_if.o_data_out}, 32'd0);
      chk("rst_next_hop", {16'd0, bus_if.o_next_hop}, 32'hFFFF);
      chk("rst_found",    {31'd0, bus_if.o_found},    32'd0);
      chk("rst_done",     {31'd0, bus_if.o_done},     32'd0);
   endtask

   initial begin
      int base;
      int t;
      bus_if.i_en    = 1'b0;
      bus_if.i_start = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs();

      // Basic: q {9,4,7} -> index 1; 4+4+3 neighbour cycles.
      set_nb(0, 16'd1, 16'd9, 16'h0011);
      set_nb(1, 16'd2, 16'd4, 16'h0022);
      set_nb(2, 16'd1, 16'd7, 16'h0033);
      run_scan(16'd3, 16'h0022, 1'b1, 14);

      // Ties: lowest index keeps it; 4+3+3.
      clear_mem();
      set_nb(0, 16'd1, 16'd5, 16'h000A);
      set_nb(1, 16'd1, 16'd5, 16'h000B);
      set_nb(2, 16'd1, 16'd5, 16'h000C);
      run_scan(16'd3, 16'h000A, 1'b1, 13);

      // Eligibility: index 0 skipped without reading its Q-value; 2+4.
      clear_mem();
      set_nb(0, 16'd0, 16'd1, 16'h0040);
      set_nb(1, 16'd3, 16'd8, 16'h0041);
      base = q0_cnt;
      run_scan(16'd2, 16'h0041, 1'b1, 9);
      chk("q0_not_addressed", q0_cnt - base, 32'd0);

      // Empty table.
      clear_mem();
      run_scan(16'd0, 16'hFFFF, 1'b0, 3);

      // All sink counts zero; 2+2+2.
      set_nb(0, 16'd0, 16'd3, 16'h0050);
      set_nb(1, 16'd0, 16'd2, 16'h0051);
      set_nb(2, 16'd0, 16'd1, 16'h0052);
      run_scan(16'd3, 16'hFFFF, 1'b0, 9);

      // Clamp: count 20 scans only 0..15. Q-values past 15 are zero and
      // would win if read. Best is index 3: 4 + 3+3 + 4 + 12*3 = 50, +3.
      clear_mem();
      for (int i = 0; i < 16; i++) set_nb(i, 16'd1, (i == 3) ? 16'd10 : 16'd50, 16'h0100 + 16'(i));
      for (int i = 16; i < 20; i++) begin
         mem[11'h1C8 + 2*i] = 16'h0000;
         mem[11'h6AE + 2*i] = 16'h0BAD;
      end
      base = qhi_cnt;
      run_scan(16'd20, 16'h0103, 1'b1, 53);
      chk("no_q_beyond_15", qhi_cnt - base, 32'd0);

      // Reset mid-scan while in QVAL (address = qValue[0]).
      clear_mem();
      set_nb(0, 16'd1, 16'd9, 16'h0011);
      set_nb(1, 16'd2, 16'd4, 16'h0022);
      set_nb(2, 16'd1, 16'd7, 16'h0033);
      mem[11'h68A] = 16'd3;
      base = wr_total;
      arm_and_start();
      t = 0;
      while (bus_if.o_address !== 11'h1C8 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("reached_qval", (t < 50) ? 32'd1 : 32'd0, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs();
      repeat (20) @(negedge clk);
      chk("no_write_after_rst", wr_total - base, 32'd0);
      chk("idle_after_rst", {31'd0, bus_if.o_done}, 32'd0);

      // Normal completion after the aborted scan.
      run_scan(16'd3, 16'h0022, 1'b1, 14);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", wq.size() + rq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
